// File: rtl/axil_timer_slave_pkg.sv
// Shared definitions for the AXI-lite machine-timer slave.
// TIMER_MTIMECMP_EN adds the BRESP state used by the mtimecmp write channel.
package axil_timer_slave_pkg;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // Register offsets from BASE_ADDR.
  localparam logic [31:0] OFS_MTIME_LO = 32'd0;
  localparam logic [31:0] OFS_MTIME_HI = 32'd4;
  localparam logic [31:0] OFS_CMP_LO   = 32'd8;
  localparam logic [31:0] OFS_CMP_HI   = 32'd12;

`ifdef TIMER_MTIMECMP_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RDATA = 2'd1,
    ST_BRESP = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_RDATA = 1'b1
  } state_t;
`endif

endpackage

// File: rtl/axil_timer_counter.sv
// Free-running 64-bit mtime with a prescaler; tick is high on the cycle
// in which mtime advances at the next edge.
module axil_timer_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] mtime,
  output logic        tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] prescaler_reg;
  logic [63:0]   mtime_reg;

  assign tick  = (prescaler_reg == PW'(TICK_DIV - 1));
  assign mtime = mtime_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_reg <= '0;
      mtime_reg     <= '0;
    end else if (tick) begin
      prescaler_reg <= '0;
      mtime_reg     <= mtime_reg + 64'd1;
    end else begin
      prescaler_reg <= prescaler_reg + PW'(1);
    end
  end

endmodule

// File: rtl/axil_timer_slave.sv
// AXI-lite CLINT timer slave: mtime read with a tear-free high word.
// Define TIMER_MTIMECMP_EN to add the write channel, mtimecmp and mtip.
module axil_timer_slave
  import axil_timer_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'ha000_0048,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        rresp,
  output logic        rvalid
`ifdef TIMER_MTIMECMP_EN
  ,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [31:0] wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        bready,
  output logic        bresp,
  output logic        bvalid,
  output logic        mtip
`endif
);

  state_t      state_reg;
  logic [31:0] shadow_hi_reg;
  logic [31:0] rdata_reg;
  logic        rresp_reg;
  logic        rvalid_reg;

  logic [63:0] mtime;
  logic        counter_tick;
  logic        unused_tick;

  axil_timer_counter #(
    .TICK_DIV(TICK_DIV)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .mtime(mtime),
    .tick (counter_tick)
  );

  assign unused_tick = counter_tick;

  assign arready = (state_reg == ST_IDLE);
  assign rdata   = rdata_reg;
  assign rresp   = rresp_reg;
  assign rvalid  = rvalid_reg;

`ifdef TIMER_MTIMECMP_EN
  logic [63:0] mtimecmp_reg;
  logic [63:0] mtimecmp_next;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_accept;
  logic        bvalid_reg;
  logic        bresp_reg;
  logic        mtip_reg;
  logic        unused_wstrb;

  // A pending read always beats a write presented in the same cycle.
  assign awready   = (state_reg == ST_IDLE) && !arvalid;
  assign wready    = (state_reg == ST_IDLE) && !arvalid;
  assign wr_accept = awready && awvalid && wvalid;
  assign wr_cmp_lo = (awaddr == BASE_ADDR + OFS_CMP_LO);
  assign wr_cmp_hi = (awaddr == BASE_ADDR + OFS_CMP_HI);

  assign bvalid       = bvalid_reg;
  assign bresp        = bresp_reg;
  assign mtip         = mtip_reg;
  assign unused_wstrb = ^wstrb[31:4];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cmp_lane
      localparam int LANE = gi % 4;
      logic lane_hit;
      assign lane_hit = wr_accept && wstrb[LANE] && ((gi < 4) ? wr_cmp_lo : wr_cmp_hi);
      assign mtimecmp_next[gi*8 +: 8] = lane_hit ? wdata[LANE*8 +: 8] : mtimecmp_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp_reg <= '1;
      mtip_reg     <= 1'b0;
    end else begin
      mtimecmp_reg <= mtimecmp_next;
      mtip_reg     <= (mtime >= mtimecmp_reg);
    end
  end
`endif

  // Read decode happens in the handshake cycle so the low word and the
  // shadowed high word come from the same mtime sample.
  logic        rd_lo_hit;
  logic [31:0] rd_data_next;
  logic        rd_resp_next;

  assign rd_lo_hit = (araddr == BASE_ADDR + OFS_MTIME_LO);

  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_ERR;
    if (rd_lo_hit) begin
      rd_data_next = mtime[31:0];
      rd_resp_next = RESP_OKAY;
    end else if (araddr == BASE_ADDR + OFS_MTIME_HI) begin
      rd_data_next = shadow_hi_reg;
      rd_resp_next = RESP_OKAY;
    end
`ifdef TIMER_MTIMECMP_EN
    else if (araddr == BASE_ADDR + OFS_CMP_LO) begin
      rd_data_next = mtimecmp_reg[31:0];
      rd_resp_next = RESP_OKAY;
    end else if (araddr == BASE_ADDR + OFS_CMP_HI) begin
      rd_data_next = mtimecmp_reg[63:32];
      rd_resp_next = RESP_OKAY;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      shadow_hi_reg <= '0;
      rdata_reg     <= '0;
      rresp_reg     <= RESP_OKAY;
      rvalid_reg    <= 1'b0;
`ifdef TIMER_MTIMECMP_EN
      bvalid_reg    <= 1'b0;
      bresp_reg     <= RESP_OKAY;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arvalid) begin
            state_reg  <= ST_RDATA;
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data_next;
            rresp_reg  <= rd_resp_next;
            if (rd_lo_hit) begin
              shadow_hi_reg <= mtime[63:32];
            end
          end
`ifdef TIMER_MTIMECMP_EN
          else if (awvalid && wvalid) begin
            state_reg  <= ST_BRESP;
            bvalid_reg <= 1'b1;
            bresp_reg  <= (wr_cmp_lo || wr_cmp_hi) ? RESP_OKAY : RESP_ERR;
          end
`endif
        end
        ST_RDATA: begin
          if (rready) begin
            state_reg  <= ST_IDLE;
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
          end
        end
`ifdef TIMER_MTIMECMP_EN
        ST_BRESP: begin
          if (bready) begin
            state_reg  <= ST_IDLE;
            bvalid_reg <= 1'b0;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_timer_slave.sv
// Randomized bench for axil_timer_slave with a cycle-level behavioural model
// plus directed checks; TIMER_MTIMECMP_EN enables the write/mtip tests.
`timescale 1ns/1ps
module tb_axil_timer_slave;

  localparam logic [31:0] BASE = 32'ha000_0048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] araddr  = '0;
  logic        arvalid = 1'b0;
  logic        rready  = 1'b0;
  logic        arready, rvalid, rresp;
  logic [31:0] rdata;

  logic [31:0] araddr4  = '0;
  logic        arvalid4 = 1'b0;
  logic        rready4  = 1'b0;
  logic        arready4, rvalid4, rresp4;
  logic [31:0] rdata4;

`ifdef TIMER_MTIMECMP_EN
  logic [31:0] awaddr = '0, wdata = '0, wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        awready, wready, bresp, bvalid, mtip;
  logic        awready4, wready4, bresp4, bvalid4, mtip4;
`endif

  axil_timer_slave #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid)
`ifdef TIMER_MTIMECMP_EN
    , .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bready(bready), .bresp(bresp), .bvalid(bvalid), .mtip(mtip)
`endif
  );

  axil_timer_slave #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .araddr(araddr4), .arvalid(arvalid4), .arready(arready4),
    .rready(rready4), .rdata(rdata4), .rresp(rresp4), .rvalid(rvalid4)
`ifdef TIMER_MTIMECMP_EN
    , .awaddr(32'h0), .awvalid(1'b0), .awready(awready4),
    .wdata(32'h0), .wstrb(32'h0), .wvalid(1'b0), .wready(wready4),
    .bready(1'b0), .bresp(bresp4), .bvalid(bvalid4), .mtip(mtip4)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mtime is simply the number of non-reset edges seen
  // (TICK_DIV = 1), unless the bench is overriding it.
  longint unsigned m_edges  = 0;
  bit              m_rpend  = 1'b0;
  bit              m_bpend  = 1'b0;
  bit              m_rresp  = 1'b0;
  bit              m_bresp  = 1'b0;
  bit              m_mtip   = 1'b0;
  logic [31:0]     m_rdata  = '0;
  logic [31:0]     m_shadow = '0;
  logic [63:0]     m_cmp    = '1;
  bit              forcing  = 1'b0;
  logic [63:0]     force_val = '0;
  logic [63:0]     mt_s;

  function automatic void m_read(input logic [31:0] a, input logic [63:0] mt);
    m_rresp = 1'b0;
    case (a - BASE)
      32'd0:  begin m_rdata = mt[31:0]; m_shadow = mt[63:32]; end
      32'd4:  m_rdata = m_shadow;
`ifdef TIMER_MTIMECMP_EN
      32'd8:  m_rdata = m_cmp[31:0];
      32'd12: m_rdata = m_cmp[63:32];
`endif
      default: begin m_rdata = 32'h0; m_rresp = 1'b1; end
    endcase
  endfunction

`ifdef TIMER_MTIMECMP_EN
  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int base_bit;
    m_bresp = 1'b1;
    base_bit = -1;
    if (a == BASE + 32'd8)  base_bit = 0;
    if (a == BASE + 32'd12) base_bit = 32;
    if (base_bit >= 0) begin
      m_bresp = 1'b0;
      for (int b = 0; b < 4; b++)
        if (s[b]) m_cmp[base_bit + 8*b +: 8] = d[8*b +: 8];
    end
  endfunction
`endif

  // Compare process: advance the model on each edge, check 1ns later.
  always @(posedge clk) begin
    mt_s = forcing ? force_val : 64'(m_edges);
    if (rst) begin
      m_edges = 0; m_rpend = 1'b0; m_bpend = 1'b0; m_rdata = '0;
      m_shadow = '0; m_cmp = '1; m_mtip = 1'b0; m_rresp = 1'b0; m_bresp = 1'b0;
    end else begin
`ifdef TIMER_MTIMECMP_EN
      m_mtip = (mt_s >= m_cmp);
`endif
      if (m_rpend) begin
        if (rready) m_rpend = 1'b0;
      end
`ifdef TIMER_MTIMECMP_EN
      else if (m_bpend) begin
        if (bready) m_bpend = 1'b0;
      end
`endif
      else if (arvalid) begin
        m_rpend = 1'b1;
        m_read(araddr, mt_s);
      end
`ifdef TIMER_MTIMECMP_EN
      else if (awvalid && wvalid) begin
        m_write(awaddr, wdata, wstrb[3:0]);
        m_bpend = 1'b1;
      end
`endif
      m_edges++;
    end
    #1;
    chk("cmp_arready", arready, !(m_rpend || m_bpend));
    chk("cmp_rvalid", rvalid, m_rpend);
    chk("cmp_rdata", rdata, m_rpend ? m_rdata : 32'h0);
    if (m_rpend) chk("cmp_rresp", rresp, m_rresp);
`ifdef TIMER_MTIMECMP_EN
    chk("cmp_awready", awready, !(m_rpend || m_bpend) && !arvalid);
    chk("cmp_wready", wready, !(m_rpend || m_bpend) && !arvalid);
    chk("cmp_bvalid", bvalid, m_bpend);
    if (m_bpend) chk("cmp_bresp", bresp, m_bresp);
    chk("cmp_mtip", mtip, m_mtip);
`endif
  end

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic r);
    @(negedge clk);
    chk("rd_pre_arready", arready, 1'b1);
    chk("rd_pre_rvalid", rvalid, 1'b0);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #2;
    chk("rd_latency_rvalid", rvalid, 1'b1);
    d = rdata; r = rresp;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #2;
    chk("rd_done_rvalid", rvalid, 1'b0);
    chk("rd_done_arready", arready, 1'b1);
    @(negedge clk);
    rready = 1'b0;
    $display("read  addr=%08h data=%08h resp=%0d", a, d, r);
  endtask

`ifdef TIMER_MTIMECMP_EN
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] s, input logic exp_resp);
    @(negedge clk);
    chk("wr_pre_awready", awready, 1'b1);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #2;
    chk("wr_bvalid", bvalid, 1'b1);
    chk("wr_bresp", bresp, exp_resp);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #2;
    chk("wr_done_bvalid", bvalid, 1'b0);
    @(negedge clk);
    bready = 1'b0;
    $display("write addr=%08h data=%08h strb=%08h resp=%0d", a, d, s, exp_resp);
  endtask
`endif

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return BASE;
      1: return BASE + 32'd4;
      2: return BASE + 32'd8;
      3: return BASE + 32'd12;
      4: return BASE + 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] d, d0;
    logic        r, r0;
    int          hit;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_arready", arready, 1'b1);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", rresp, 1'b0);
`ifdef TIMER_MTIMECMP_EN
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b1);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 1'b0);
    chk("rst_mtip", mtip, 1'b0);
`endif

    // 10 idle cycles, then read the low word
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    rd(BASE, d, r);
    chk("idle10_lo", d, 32'd10);
    chk("idle10_resp", r, 1'b0);
    rd(BASE + 32'd4, d, r);
    chk("idle10_hi", d, 32'd0);

    // rready stalled 5 cycles; arvalid kept high must be ignored
    @(negedge clk);
    araddr = BASE; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #2;
    chk("stall_rvalid0", rvalid, 1'b1);
    d0 = rdata; r0 = rresp;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("stall_rvalid", rvalid, 1'b1);
      chk("stall_rdata", rdata, d0);
      chk("stall_rresp", rresp, r0);
      chk("stall_arready", arready, 1'b0);
    end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #2;
    chk("stall_release", rvalid, 1'b0);
    @(posedge clk); #2;
    chk("stall_single_resp", rvalid, 1'b0);
    @(negedge clk) rready = 1'b0;
    $display("read  addr=%08h data=%08h resp=%0d (stalled)", BASE, d0, r0);

    // Unmapped address
    rd(32'ha000_0000, d, r);
    chk("bad_resp", r, 1'b1);
    chk("bad_data", d, 32'h0);
`ifndef TIMER_MTIMECMP_EN
    rd(BASE + 32'd8, d, r);
    chk("cmp_absent_resp", r, 1'b1);
`else
    rd(BASE + 32'd8, d, r);
    chk("cmp_lo_reset", d, 32'hFFFF_FFFF);
    chk("cmp_lo_resp", r, 1'b0);
`endif

    // Low/high read across a carry: high comes from the shadow
    forcing = 1'b1; force_val = 64'h0000_0000_FFFF_FFFE;
    force dut.mtime = 64'h0000_0000_FFFF_FFFE;
    rd(BASE, d, r);
    chk("carry_lo", d, 32'hFFFF_FFFE);
    force_val = 64'h0000_0001_0000_0003;
    force dut.mtime = 64'h0000_0001_0000_0003;
    rd(BASE + 32'd4, d, r);
    chk("carry_hi_shadow", d, 32'h0);
    release dut.mtime;
    forcing = 1'b0;

    // Reset while a response is pending
    @(negedge clk);
    araddr = BASE; arvalid = 1'b1;
    @(posedge clk); #2;
    chk("rstrd_rvalid", rvalid, 1'b1);
    @(negedge clk);
    arvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #2;
    chk("rstrd_drop", rvalid, 1'b0);
    @(negedge clk) rst = 1'b0;

`ifdef TIMER_MTIMECMP_EN
    wr(BASE + 32'd8, 32'd20, 32'h0000_000F, 1'b0);
    wr(BASE + 32'd12, 32'd0, 32'h0000_000F, 1'b0);
    hit = 0;
    for (int i = 0; i < 100 && hit == 0; i++) begin
      @(posedge clk); #2;
      if (m_edges == 64'd20) hit = 1;
    end
    chk("mtip_wait_timeout", hit, 1);
    if (hit == 1) begin
      chk("mtip_at_20", mtip, 1'b0);
      @(posedge clk); #2;
      chk("mtip_after_20", mtip, 1'b1);
    end
    wr(BASE, 32'h1234, 32'h0000_000F, 1'b1);
    wr(BASE + 32'd8, 32'hAABB_CCDD, 32'hFFFF_FFF2, 1'b0);
    rd(BASE + 32'd8, d, r);
    chk("strobe_lane1", d, 32'h0000_CC14);

    // Simultaneous read and write: read first
    @(negedge clk);
    araddr = BASE + 32'd12; arvalid = 1'b1; rready = 1'b0;
    awaddr = BASE + 32'd12; wdata = 32'h5; wstrb = 32'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #2;
    chk("sim_rvalid", rvalid, 1'b1);
    chk("sim_bvalid_wait", bvalid, 1'b0);
    chk("sim_rdata", rdata, 32'h0);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #2;
    chk("sim_rdone", rvalid, 1'b0);
    @(posedge clk); #2;
    chk("sim_bvalid", bvalid, 1'b1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; rready = 1'b0;
    @(negedge clk) bready = 1'b0;
    $display("read  addr=%08h then write data=%08h (simultaneous)", BASE + 32'd12, 32'h5);
`endif

    // TICK_DIV = 4: 40 cycles give mtime = 10
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    araddr4 = BASE; arvalid4 = 1'b1;
    @(posedge clk); #2;
    chk("div4_rvalid", rvalid4, 1'b1);
    chk("div4_rdata", rdata4, 32'd10);
    chk("div4_rresp", rresp4, 1'b0);
    @(negedge clk);
    arvalid4 = 1'b0; rready4 = 1'b1;
    @(posedge clk); #2;
    chk("div4_done", rvalid4, 1'b0);
    @(negedge clk) rready4 = 1'b0;
    $display("read  addr=%08h data=%08h (TICK_DIV=4)", BASE, rdata4);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      arvalid = ($urandom_range(0, 3) == 0);
      araddr  = pick_addr();
      rready  = $urandom_range(0, 1);
`ifdef TIMER_MTIMECMP_EN
      awvalid = ($urandom_range(0, 2) == 0);
      wvalid  = ($urandom_range(0, 2) != 0);
      awaddr  = pick_addr();
      wdata   = $urandom;
      wstrb   = $urandom;
      bready  = $urandom_range(0, 1);
`endif
    end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
`ifdef TIMER_MTIMECMP_EN
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
`endif
    repeat (4) @(posedge clk);
    #2;
    chk("drain_arready", arready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
